// File: rtl/booth3_pkg.sv
// Shared types and constants for the radix-8 Booth
// partial-product generator.
package booth3_pkg;

  localparam int OP_W  = 8;
  localparam int PP_W  = 10;
  localparam int N_DIG = 3;

  typedef enum logic [1:0] {
    IDLE,
    HARD,
    ENC,
    DONE
  } state_t;

  typedef struct packed {
    logic       neg;
    logic [2:0] mag;
  } digit_t;

  // Window {y[3k+2], y[3k+1], y[3k], y[3k-1]} -> signed digit.
  // A window of all ones is a zero digit, never "negative zero".
  function automatic digit_t booth_digit(input logic [3:0] win);
    digit_t     d;
    logic [2:0] p;
    p = {1'b0, win[2], 1'b0}
      + {2'b00, win[1]}
      + {2'b00, win[0]};
    if (win[3]) begin
      d.mag = 3'd4 - p;
      d.neg = (p != 3'd4);
    end else begin
      d.mag = p;
      d.neg = 1'b0;
    end
    return d;
  endfunction

endpackage

// File: rtl/booth3_pp_gen_enc.sv
// Combinational Booth-3 digit encoder: window + multiples
// in, one's-complement partial product with s/e bits out.
module booth3_enc
  import booth3_pkg::*;
(
  input  logic [3:0]      win_i,
  input  logic [PP_W-1:0] x1_i,
  input  logic [PP_W-1:0] x2_i,
  input  logic [PP_W-1:0] x3_i,
  input  logic [PP_W-1:0] x4_i,
  output logic [PP_W-1:0] pp_o,
  output logic            s_o,
  output logic            e_o
);

  digit_t          dig;
  logic [PP_W-1:0] mag;

  // Select the multiple, invert for negative digits.
  always_comb begin
    dig = booth_digit(win_i);
    mag = '0;
    case (dig.mag)
      3'd1:    mag = x1_i;
      3'd2:    mag = x2_i;
      3'd3:    mag = x3_i;
      3'd4:    mag = x4_i;
      default: mag = '0;
    endcase
    pp_o = dig.neg ? ~mag : mag;
    s_o  = dig.neg;
    e_o  = ~pp_o[PP_W-1];
  end

endmodule

// File: rtl/booth3_pp_gen.sv
// Sequential radix-8 partial-product generator: one Booth
// digit per cycle, bundle handed off over valid/ready.
module booth3_pp_gen
  import booth3_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  x,
  input  logic [OP_W-1:0]  y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PP_W-1:0]  pp0,
  output logic [PP_W-1:0]  pp1,
  output logic [PP_W-1:0]  pp2,
  output logic [N_DIG-1:0] s,
  output logic [N_DIG-1:0] e
);

  state_t           state_q;
  logic [1:0]       k_q;
  logic [OP_W-1:0]  x_q;
  logic [OP_W-1:0]  y_q;
  logic [PP_W-1:0]  x3_q;
  logic [PP_W-1:0]  pp0_q;
  logic [PP_W-1:0]  pp1_q;
  logic [PP_W-1:0]  pp2_q;
  logic [N_DIG-1:0] s_q;
  logic [N_DIG-1:0] e_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [PP_W-1:0]  x1;
  logic [PP_W-1:0]  x2;
  logic [PP_W-1:0]  x4;
  logic [PP_W-1:0]  x3_d;
  logic [9:0]       yx;
  logic [3:0]       win_d;
  logic [PP_W-1:0]  enc_pp;
  logic             enc_s;
  logic             enc_e;

  // Easy multiples from the registered multiplicand.
  always_comb begin
    x1   = {{(PP_W-OP_W){x_q[OP_W-1]}}, x_q};
    x2   = {x1[PP_W-2:0], 1'b0};
    x4   = {x1[PP_W-3:0], 2'b00};
    x3_d = x1 + x2;
  end

  // Pick the window for digit k; y[-1]=0, y[8]=y[7].
  always_comb begin
    yx    = {y_q[OP_W-1], y_q, 1'b0};
    win_d = yx[3:0];
    case (k_q)
      2'd1:    win_d = yx[6:3];
      2'd2:    win_d = yx[9:6];
      default: win_d = yx[3:0];
    endcase
  end

  booth3_enc u_enc (
    .win_i (win_d),
    .x1_i  (x1),
    .x2_i  (x2),
    .x3_i  (x3_q),
    .x4_i  (x4),
    .pp_o  (enc_pp),
    .s_o   (enc_s),
    .e_o   (enc_e)
  );

  // Control FSM with registered handshake and result fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      x_q         <= '0;
      y_q         <= '0;
      x3_q        <= '0;
      pp0_q       <= '0;
      pp1_q       <= '0;
      pp2_q       <= '0;
      s_q         <= '0;
      e_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            x_q        <= x;
            y_q        <= y;
            in_ready_q <= 1'b0;
            state_q    <= HARD;
          end
        end
        HARD: begin
          x3_q    <= x3_d;
          k_q     <= '0;
          state_q <= ENC;
        end
        ENC: begin
          case (k_q)
            2'd0: begin
              pp0_q  <= enc_pp;
              s_q[0] <= enc_s;
              e_q[0] <= enc_e;
            end
            2'd1: begin
              pp1_q  <= enc_pp;
              s_q[1] <= enc_s;
              e_q[1] <= enc_e;
            end
            default: begin
              pp2_q  <= enc_pp;
              s_q[2] <= enc_s;
              e_q[2] <= enc_e;
            end
          endcase
          if (k_q == 2'd2) begin
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            k_q <= k_q + 2'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign pp0       = pp0_q;
  assign pp1       = pp1_q;
  assign pp2       = pp2_q;
  assign s         = s_q;
  assign e         = e_q;

endmodule
